// File: rtl/lc_ctrl_pkg.sv
// rtl/lc_ctrl_pkg.sv - life cycle multi-bit boolean type shared with lc_ctrl
package lc_ctrl_pkg;

    typedef logic [3:0] lc_tx_t;

    localparam lc_tx_t On  = 4'b0101;
    localparam lc_tx_t Off = 4'b1010;

endpackage

// File: rtl/lc_ctrl_trans_pkg.sv
// rtl/lc_ctrl_trans_pkg.sv - FSM encoding, status codes and write addresses for the transition initiator
package lc_ctrl_trans_pkg;

    // Walsh-row codes: every pair differs in exactly 8 bits
    typedef enum logic [15:0] {
        StIdle    = 16'hFF00,
        StClaim   = 16'hF0F0,
        StWrite   = 16'hCCCC,
        StWait    = 16'hAAAA,
        StRelease = 16'h0FF0,
        StError   = 16'h3C3C
    } state_e;

    typedef enum logic [2:0] {
        StatOk           = 3'd0,
        StatTokenErr     = 3'd1,
        StatTransErr     = 3'd2,
        StatBadTarget    = 3'd3,
        StatClaimTimeout = 3'd4,
        StatDoneTimeout  = 3'd5,
        StatClaimLost    = 3'd6,
        StatNoStatus     = 3'd7
    } status_e;

    localparam logic [2:0] AddrToken0 = 3'd0;
    localparam logic [2:0] AddrTarget = 3'd4;
    localparam logic [2:0] AddrStart  = 3'd5;

endpackage

// File: rtl/lc_ctrl_trans_initiator_if.sv
// rtl/lc_ctrl_trans_initiator_if.sv - request, response, mutex and word-write signals of the initiator
interface lc_ctrl_trans_initiator_if
    import lc_ctrl_pkg::*;
();
    logic           req_valid;
    logic           req_ready;
    logic [4:0]     req_target;
    logic [127:0]   req_token;
    logic           rsp_valid;
    logic [2:0]     rsp_status;
    lc_tx_t         claim;
    lc_tx_t         claim_grant;
    logic           wr_valid;
    logic           wr_ready;
    logic [2:0]     wr_addr;
    logic [31:0]    wr_data;
    logic           lc_done;
    logic           lc_success;
    logic           lc_token_err;
    logic           lc_trans_err;
    logic           fatal;

    modport master (
        input  req_valid, req_target, req_token, claim_grant, wr_ready,
               lc_done, lc_success, lc_token_err, lc_trans_err,
        output req_ready, rsp_valid, rsp_status, claim, wr_valid, wr_addr, wr_data, fatal
    );

    modport slave (
        output req_valid, req_target, req_token, claim_grant, wr_ready,
               lc_done, lc_success, lc_token_err, lc_trans_err,
        input  req_ready, rsp_valid, rsp_status, claim, wr_valid, wr_addr, wr_data, fatal
    );
endinterface

// File: rtl/lc_ctrl_trans_timer.sv
// rtl/lc_ctrl_trans_timer.sv - loadable down-counter; expired while the count sits at zero
module lc_ctrl_trans_timer #(
    parameter int unsigned Width = 17
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             load,
    input  logic [Width-1:0] load_value,
    output logic             expired
);

    logic [Width-1:0] count_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            count_q <= '0;
        end else if (load) begin
            count_q <= load_value;
        end else if (count_q != '0) begin
            count_q <= count_q - 1'b1;
        end
    end

    assign expired = (count_q == '0);

endmodule

// File: rtl/lc_ctrl_trans_initiator.sv
// rtl/lc_ctrl_trans_initiator.sv - claims the lc_ctrl mutex, writes token/target/start, returns one status
module lc_ctrl_trans_initiator
    import lc_ctrl_pkg::*;
    import lc_ctrl_trans_pkg::*;
#(
    parameter int unsigned NumLcStates  = 21,
    parameter int unsigned ClaimTimeout = 256,
    parameter int unsigned DoneTimeout  = 65536
) (
    input  logic                        clk_i,
    input  logic                        rst_i,
    lc_ctrl_trans_initiator_if.master   bus
);

    state_e       state_q, state_d;
    status_e      status_q, status_d;
    logic [127:0] token_q, token_d;
    logic [4:0]   target_q, target_d;
    logic [2:0]   idx_q, idx_d;

    logic         timer_load;
    logic [16:0]  timer_value;
    logic         timer_expired;

    logic         req_ready, rsp_valid, wr_valid, fatal;
    lc_tx_t       claim;
    logic [31:0]  wr_data;

    lc_ctrl_trans_timer #(.Width(17)) u_timer (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .load       (timer_load),
        .load_value (timer_value),
        .expired    (timer_expired)
    );

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q  <= StIdle;
            status_q <= StatOk;
            token_q  <= '0;
            target_q <= '0;
            idx_q    <= AddrToken0;
        end else begin
            state_q  <= state_d;
            status_q <= status_d;
            token_q  <= token_d;
            target_q <= target_d;
            idx_q    <= idx_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        status_d    = status_q;
        token_d     = token_q;
        target_d    = target_q;
        idx_d       = idx_q;
        timer_load  = 1'b0;
        timer_value = '0;
        req_ready   = 1'b0;
        rsp_valid   = 1'b0;
        claim       = Off;
        wr_valid    = 1'b0;
        fatal       = 1'b0;

        unique case (state_q)
            StIdle: begin
                // Held low during reset so the first accept happens after release
                req_ready = !rst_i;
                if (bus.req_valid && req_ready) begin
                    token_d  = bus.req_token;
                    target_d = bus.req_target;
                    idx_d    = AddrToken0;
                    if (32'(bus.req_target) >= NumLcStates) begin
                        status_d = StatBadTarget;
                        state_d  = StRelease;
                    end else begin
                        timer_load  = 1'b1;
                        timer_value = 17'(ClaimTimeout - 1);
                        state_d     = StClaim;
                    end
                end
            end
            StClaim: begin
                claim = On;
                if (bus.claim_grant == On) begin
                    state_d = StWrite;
                end else if (bus.claim_grant != Off) begin
                    state_d = StError;
                end else if (timer_expired) begin
                    status_d = StatClaimTimeout;
                    state_d  = StRelease;
                end
            end
            StWrite: begin
                claim    = On;
                wr_valid = 1'b1;
                if (bus.claim_grant == Off) begin
                    status_d = StatClaimLost;
                    state_d  = StRelease;
                end else if (bus.claim_grant != On) begin
                    state_d = StError;
                end else if (bus.wr_ready) begin
                    if (idx_q == AddrStart) begin
                        timer_load  = 1'b1;
                        timer_value = 17'(DoneTimeout - 1);
                        state_d     = StWait;
                    end else begin
                        idx_d = idx_q + 3'd1;
                    end
                end
            end
            StWait: begin
                claim = On;
                if (bus.claim_grant == Off) begin
                    status_d = StatClaimLost;
                    state_d  = StRelease;
                end else if (bus.claim_grant != On) begin
                    state_d = StError;
                end else if (bus.lc_done) begin
                    if (bus.lc_token_err)      status_d = StatTokenErr;
                    else if (bus.lc_trans_err) status_d = StatTransErr;
                    else if (bus.lc_success)   status_d = StatOk;
                    else                       status_d = StatNoStatus;
                    state_d = StRelease;
                end else if (timer_expired) begin
                    status_d = StatDoneTimeout;
                    state_d  = StRelease;
                end
            end
            StRelease: begin
                rsp_valid = 1'b1;
                token_d   = '0;
                state_d   = StIdle;
            end
            StError: begin
                fatal = 1'b1;
            end
            default: begin
                state_d = StError;
            end
        endcase
    end

    always_comb begin
        wr_data = '0;
        if (wr_valid) begin
            case (idx_q)
                AddrTarget: wr_data = {27'b0, target_q};
                AddrStart:  wr_data = 32'h1;
                default:    wr_data = token_q[{idx_q[1:0], 5'd0} +: 32];
            endcase
        end
    end

    assign bus.req_ready  = req_ready;
    assign bus.rsp_valid  = rsp_valid;
    assign bus.rsp_status = rsp_valid ? status_q : StatOk;
    assign bus.claim      = claim;
    assign bus.wr_valid   = wr_valid;
    assign bus.wr_addr    = wr_valid ? idx_q : 3'd0;
    assign bus.wr_data    = wr_data;
    assign bus.fatal      = fatal;

endmodule

// File: tb/tb_lc_ctrl_trans_initiator.sv
// tb/tb_lc_ctrl_trans_initiator.sv - directed bench with a procedural reference model of the initiator
module tb_lc_ctrl_trans_initiator;

    localparam logic [3:0] ON  = 4'b0101;
    localparam logic [3:0] OFF = 4'b1010;
    localparam int NUM_STATES = 21;
    localparam int CLAIM_TO   = 256;
    localparam int DONE_TO    = 2048;
    localparam logic [127:0] TOK = 128'h01234567_89ABCDEF_FEDCBA98_7654CDEF;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   n_checks = 0;
    int   n_fail = 0;

    lc_ctrl_trans_initiator_if bus();

    lc_ctrl_trans_initiator #(
        .NumLcStates  (NUM_STATES),
        .ClaimTimeout (CLAIM_TO),
        .DoneTimeout  (DONE_TO)
    ) dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Reference model: expected outputs for the current cycle
    bit          m_idle, m_rsp, m_claim, m_wr, m_fatal;
    logic [2:0]  m_status, m_addr;
    logic [31:0] m_data;

    task automatic m_set(bit idle, bit rsp, logic [2:0] st, bit clm, bit wr,
                         logic [2:0] a, logic [31:0] d, bit fat);
        m_idle = idle; m_rsp = rsp; m_status = st; m_claim = clm;
        m_wr = wr; m_addr = a; m_data = d; m_fatal = fat;
    endtask

    task automatic m_step(output bit r);
        @(posedge clk);
        r = rst;
    endtask

    function automatic logic [31:0] m_word(int w, logic [4:0] tgt, logic [127:0] tok);
        if (w < 4) return tok[32*w +: 32];
        if (w == 4) return {27'b0, tgt};
        return 32'h1;
    endfunction

    task automatic m_release(logic [2:0] st);
        bit r;
        m_set(0, 1, st, 0, 0, 3'd0, 32'h0, 0);
        m_step(r);
    endtask

    task automatic m_fatal_loop();
        bit r;
        m_set(0, 0, 3'd0, 0, 0, 3'd0, 32'h0, 1);
        forever begin
            m_step(r);
            if (r) return;
        end
    endtask

    task automatic model_txn();
        bit r;
        logic [4:0]   tgt;
        logic [127:0] tok;
        logic [3:0]   g;
        int n;
        m_set(1, 0, 3'd0, 0, 0, 3'd0, 32'h0, 0);
        forever begin
            m_step(r);
            if (r) return;
            if (bus.req_valid) break;
        end
        tgt = bus.req_target;
        tok = bus.req_token;
        if (int'(tgt) >= NUM_STATES) begin
            m_release(3'd3);
            return;
        end
        m_set(0, 0, 3'd0, 1, 0, 3'd0, 32'h0, 0);
        n = 0;
        forever begin
            m_step(r);
            if (r) return;
            g = bus.claim_grant;
            if (g == ON) break;
            if (g != OFF) begin m_fatal_loop(); return; end
            if (n == CLAIM_TO - 1) begin m_release(3'd4); return; end
            n++;
        end
        for (int w = 0; w < 6; w++) begin
            m_set(0, 0, 3'd0, 1, 1, w[2:0], m_word(w, tgt, tok), 0);
            forever begin
                m_step(r);
                if (r) return;
                g = bus.claim_grant;
                if (g == OFF) begin m_release(3'd6); return; end
                if (g != ON) begin m_fatal_loop(); return; end
                if (bus.wr_ready) break;
            end
        end
        m_set(0, 0, 3'd0, 1, 0, 3'd0, 32'h0, 0);
        n = 0;
        forever begin
            m_step(r);
            if (r) return;
            g = bus.claim_grant;
            if (g == OFF) begin m_release(3'd6); return; end
            if (g != ON) begin m_fatal_loop(); return; end
            if (bus.lc_done) begin
                m_release(bus.lc_token_err ? 3'd1 : bus.lc_trans_err ? 3'd2 :
                          bus.lc_success ? 3'd0 : 3'd7);
                return;
            end
            if (n == DONE_TO - 1) begin m_release(3'd5); return; end
            n++;
        end
    endtask

    initial forever model_txn();

    // Per-cycle compare of every output against the model
    initial begin
        logic [45:0] act, exp;
        @(posedge clk);
        forever begin
            @(negedge clk);
            exp = {m_idle && !rst, m_rsp, m_status, (m_claim ? ON : OFF),
                   m_wr, m_addr, m_data, m_fatal};
            act = {bus.req_ready, bus.rsp_valid, bus.rsp_status, bus.claim,
                   bus.wr_valid, bus.wr_addr, bus.wr_data, bus.fatal};
            n_checks++;
            if (act !== exp) begin
                n_fail++;
                $display("FAIL outputs cycle %0d: actual %h required %h", cyc, act, exp);
            end
        end
    end

    // Monitor feeding the literal checks
    logic [2:0]  wr_addr_q[$];
    logic [31:0] wr_data_q[$];
    logic [2:0]  rsp_q[$];
    int rsp_cyc, acc_cyc, last_wr_cyc, claim_cnt;
    logic [3:0] rsp_claim;

    always @(negedge clk) begin
        if (!rst) begin
            if (bus.wr_valid && bus.wr_ready) begin
                wr_addr_q.push_back(bus.wr_addr);
                wr_data_q.push_back(bus.wr_data);
                last_wr_cyc = cyc;
            end
            if (bus.rsp_valid) begin
                rsp_q.push_back(bus.rsp_status);
                rsp_cyc   = cyc;
                rsp_claim = bus.claim;
            end
            if (bus.claim == ON) claim_cnt++;
            if (bus.req_valid && bus.req_ready) acc_cyc = cyc;
        end
    end

    task automatic chk(string name, logic [63:0] act, logic [63:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: actual %0h required %0h", name, act, req);
        end
    endtask

    task automatic clear_mon();
        wr_addr_q.delete();
        wr_data_q.delete();
        rsp_q.delete();
        claim_cnt = 0;
    endtask

    task automatic idle_inputs();
        bus.req_valid    = 1'b0;
        bus.req_target   = 5'd0;
        bus.req_token    = '0;
        bus.claim_grant  = OFF;
        bus.wr_ready     = 1'b1;
        bus.lc_done      = 1'b0;
        bus.lc_success   = 1'b0;
        bus.lc_token_err = 1'b0;
        bus.lc_trans_err = 1'b0;
    endtask

    task automatic send_req(logic [4:0] tgt, logic [127:0] tok);
        int k = 0;
        bus.req_target = tgt;
        bus.req_token  = tok;
        bus.req_valid  = 1'b1;
        do begin
            @(negedge clk);
            k++;
        end while (!bus.req_ready && k < 50);
        n_checks++;
        if (!bus.req_ready) begin
            n_fail++;
            $display("FAIL req_accept_timeout: actual ready 0 required 1");
        end
        @(posedge clk);
        #1;
        bus.req_valid = 1'b0;
    endtask

    task automatic wait_writes(int n, int limit);
        int k = 0;
        while (wr_addr_q.size() < n && k < limit) begin
            @(posedge clk);
            k++;
        end
        #1;
        n_checks++;
        if (wr_addr_q.size() < n) begin
            n_fail++;
            $display("FAIL write_timeout: actual %0d writes required %0d", wr_addr_q.size(), n);
        end
    endtask

    task automatic wait_rsp(int limit);
        int k = 0;
        while (rsp_q.size() == 0 && k < limit) begin
            @(posedge clk);
            k++;
        end
        #1;
        n_checks++;
        if (rsp_q.size() == 0) begin
            n_fail++;
            $display("FAIL rsp_timeout: actual none required one response");
            rsp_q.push_back(3'bx);
        end
    endtask

    task automatic pulse_done(bit tok_err, bit trans_err, bit success);
        bus.lc_done      = 1'b1;
        bus.lc_token_err = tok_err;
        bus.lc_trans_err = trans_err;
        bus.lc_success   = success;
        @(posedge clk);
        #1;
        bus.lc_done      = 1'b0;
        bus.lc_token_err = 1'b0;
        bus.lc_trans_err = 1'b0;
        bus.lc_success   = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    initial begin
        logic [31:0] exp_data [6];
        int tgt_cyc, k;
        exp_data = '{32'h7654CDEF, 32'hFEDCBA98, 32'h89ABCDEF, 32'h01234567, 32'h5, 32'h1};
        idle_inputs();
        clear_mon();

        // Reset values
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("reset_outputs", {bus.req_ready, bus.rsp_valid, bus.rsp_status, bus.claim,
                              bus.wr_valid, bus.wr_addr, bus.wr_data, bus.fatal},
            {1'b0, 1'b0, 3'd0, OFF, 1'b0, 3'd0, 32'h0, 1'b0});
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        chk("ready_after_reset", bus.req_ready, 1);

        // Nominal transition, grant after three Claim cycles
        @(posedge clk); #1;
        clear_mon();
        send_req(5'd5, TOK);
        repeat (3) @(posedge clk);
        #1;
        bus.claim_grant = ON;
        wait_writes(6, 50);
        for (int i = 0; i < 6; i++) begin
            if (i < wr_addr_q.size()) begin
                chk($sformatf("nominal_addr%0d", i), wr_addr_q[i], i);
                chk($sformatf("nominal_data%0d", i), wr_data_q[i], exp_data[i]);
            end
        end
        repeat (3) @(posedge clk);
        #1;
        pulse_done(0, 0, 1);
        wait_rsp(10);
        chk("nominal_status", rsp_q[0], 0);
        chk("nominal_release_claim", rsp_claim, OFF);

        // Target at NumLcStates is rejected without a claim
        idle_inputs();
        clear_mon();
        send_req(5'd21, TOK);
        wait_rsp(10);
        chk("bad_target_status", rsp_q[0], 3);
        chk("bad_target_latency", rsp_cyc - acc_cyc, 1);
        chk("bad_target_writes", wr_addr_q.size(), 0);
        chk("bad_target_claim_cycles", claim_cnt, 0);

        // Grant held Off
        idle_inputs();
        clear_mon();
        send_req(5'd3, TOK);
        wait_rsp(400);
        chk("claim_timeout_status", rsp_q[0], 4);
        chk("claim_timeout_cycles", claim_cnt, CLAIM_TO);

        // Token error outranks success
        idle_inputs();
        bus.claim_grant = ON;
        clear_mon();
        send_req(5'd7, TOK);
        wait_writes(6, 50);
        pulse_done(1, 0, 1);
        wait_rsp(10);
        chk("token_err_status", rsp_q[0], 1);

        // Done never arrives
        clear_mon();
        send_req(5'd7, TOK);
        wait_writes(6, 50);
        wait_rsp(DONE_TO + 50);
        chk("done_timeout_status", rsp_q[0], 5);
        chk("done_timeout_latency", rsp_cyc - last_wr_cyc, DONE_TO + 1);

        // Done on the last Wait cycle wins over expiry
        clear_mon();
        send_req(5'd7, TOK);
        wait_writes(6, 50);
        tgt_cyc = last_wr_cyc + DONE_TO;
        k = 0;
        while (cyc != tgt_cyc && k < DONE_TO + 10) begin
            @(posedge clk);
            #1;
            k++;
        end
        pulse_done(0, 0, 1);
        wait_rsp(10);
        chk("done_at_expiry_status", rsp_q[0], 0);
        chk("done_at_expiry_latency", rsp_cyc - last_wr_cyc, DONE_TO + 1);

        // Invalid grant encoding is fatal and sticky
        idle_inputs();
        bus.claim_grant = 4'b1111;
        clear_mon();
        send_req(5'd2, TOK);
        repeat (20) @(posedge clk);
        #1;
        chk("fatal_set", bus.fatal, 1);
        chk("fatal_no_rsp", rsp_q.size(), 0);
        chk("fatal_not_ready", bus.req_ready, 0);
        bus.claim_grant = OFF;
        repeat (5) @(posedge clk);
        #1;
        chk("fatal_sticky", bus.fatal, 1);
        do_reset();
        @(negedge clk);
        chk("fatal_cleared", bus.fatal, 0);

        // Write backpressure keeps addr/data stable
        @(posedge clk); #1;
        idle_inputs();
        bus.claim_grant = ON;
        bus.wr_ready = 1'b0;
        clear_mon();
        send_req(5'd9, TOK);
        @(posedge clk); #1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk($sformatf("stall_word%0d", i), {bus.wr_valid, bus.wr_addr, bus.wr_data},
                {1'b1, 3'd0, 32'h7654CDEF});
        end
        @(posedge clk); #1;
        bus.wr_ready = 1'b1;
        wait_writes(6, 50);
        chk("stall_target_word", wr_data_q[4], 9);
        pulse_done(0, 0, 1);
        wait_rsp(10);
        chk("stall_status", rsp_q[0], 0);

        // Grant dropped to Off during Write
        bus.wr_ready = 1'b0;
        clear_mon();
        send_req(5'd9, TOK);
        repeat (4) @(posedge clk);
        #1;
        bus.claim_grant = OFF;
        wait_rsp(10);
        chk("claim_lost_status", rsp_q[0], 6);
        chk("claim_lost_writes", wr_addr_q.size(), 0);

        // Reset in the middle of Wait
        idle_inputs();
        bus.claim_grant = ON;
        clear_mon();
        send_req(5'd4, TOK);
        wait_writes(6, 50);
        repeat (5) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("mid_wait_reset_outputs", {bus.req_ready, bus.rsp_valid, bus.rsp_status, bus.claim,
                                       bus.wr_valid, bus.wr_addr, bus.wr_data, bus.fatal},
            {1'b0, 1'b0, 3'd0, OFF, 1'b0, 3'd0, 32'h0, 1'b0});
        chk("mid_wait_reset_no_rsp", rsp_q.size(), 0);
        @(posedge clk); #1;
        rst = 1'b0;
        idle_inputs();
        clear_mon();
        send_req(5'd31, TOK);
        wait_rsp(10);
        chk("post_reset_status", rsp_q[0], 3);

        repeat (3) @(posedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
